// File: rtl/uart_rx_unit_if.sv
// Receive-side bus of the debugger UART: the framed byte plus its done/error
// strobes and a busy flag, as produced by uart_rx_unit and consumed by the debugger FSM.
interface uart_rx_unit_if;
  logic [7:0] o_rx_data;
  logic       os_rx_done;
  logic       os_frame_err;
  logic       o_busy;

  modport master (output o_rx_data, output os_rx_done, output os_frame_err, output o_busy);
  modport slave  (input  o_rx_data, input  os_rx_done, input  os_frame_err, input  o_busy);
endinterface

// File: rtl/uart_rx_unit.sv
// 8N1 UART receiver with 16x oversampling tick generator, start-bit glitch
// rejection, stop-bit framing check and a two-flop input synchroniser.
module uart_rx_unit #(
  parameter int DIVISOR = 326
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_rx,
  uart_rx_unit_if.master rx_if
);

  localparam int OVERSAMPLE = 16;
  localparam int DIV_W      = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [3:0] S_CNT_MID  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] S_CNT_LAST = 4'(OVERSAMPLE - 1);

  logic             rx_meta_q, rx_meta_d;
  logic             rx_s_q,    rx_s_d;
  logic             rx_prev_q, rx_prev_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       state_q,   state_d;
  logic [3:0]       s_cnt_q,   s_cnt_d;
  logic [2:0]       n_cnt_q,   n_cnt_d;
  logic [7:0]       shreg_q,   shreg_d;
  logic [7:0]       data_q,    data_d;
  logic             done_q,    done_d;
  logic             err_q,     err_d;
  logic             tick;

  assign tick = (div_cnt_q == DIV_W'(DIVISOR - 1));

  always_comb begin
    rx_meta_d = i_rx;
    rx_s_d    = rx_meta_q;
    rx_prev_d = rx_s_q;
    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;

    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Only a 1->0 transition starts a frame; a line parked low never does.
        if (rx_prev_q && !rx_s_q) begin
          state_d = S_START;
          s_cnt_d = '0;
        end
      end
      S_START: begin
        if (tick) begin
          if (s_cnt_q == S_CNT_MID) begin
            s_cnt_d = '0;
            n_cnt_d = '0;
            state_d = rx_s_q ? S_IDLE : S_DATA;
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (s_cnt_q == S_CNT_LAST) begin
            shreg_d = {rx_s_q, shreg_q[7:1]};
            s_cnt_d = '0;
            if (n_cnt_q == 3'd7) state_d = S_STOP;
            else                 n_cnt_d = n_cnt_q + 1'b1;
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      S_STOP: begin
        // Leaving at mid stop bit gives half a bit of slack for a back-to-back start edge.
        if (tick) begin
          if (s_cnt_q == S_CNT_LAST) begin
            if (rx_s_q) begin
              data_d = shreg_q;
              done_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
            state_d = S_IDLE;
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      div_cnt_q <= '0;
      state_q   <= S_IDLE;
      s_cnt_q   <= '0;
      n_cnt_q   <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      rx_prev_q <= rx_prev_d;
      div_cnt_q <= div_cnt_d;
      state_q   <= state_d;
      s_cnt_q   <= s_cnt_d;
      n_cnt_q   <= n_cnt_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign rx_if.o_rx_data    = data_q;
  assign rx_if.os_rx_done   = done_q;
  assign rx_if.os_frame_err = err_q;
  assign rx_if.o_busy       = (state_q != S_IDLE);

endmodule

// File: doc/uart_rx_unit.md
# uart_rx_unit

UART receiver for the debugger unit: deserialises the host's 8N1 serial line into bytes and produces the `i_rx_data` / `is_rx_done` pair consumed by the debugger top-level FSM. It is the load, fast and step sub-FSMs' only source of host commands and program words. The block has a built-in oversampling baud-tick generator, start-bit glitch rejection, stop-bit framing check and an input synchroniser.

## Interface
- `DIVISOR`, default 326: clk cycles per oversample tick (50 MHz / (9600 baud × 16), rounded). Must be ≥ 2.
- `OVERSAMPLE`, fixed 16: ticks per bit. Not overridable.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `i_rx`  in  1  serial line, idle high, asynchronous to `clk`.
- `o_rx_data`  out  8  last correctly framed byte, LSB received first.
- `os_rx_done`  out  1  single-cycle pulse: `o_rx_data` updated this cycle.
- `os_frame_err`  out  1  single-cycle pulse: stop bit sampled low, byte discarded.
- `o_busy`  out  1  high while a frame is in progress (any state except IDLE).

## Operation
- Synchroniser: two flops on `i_rx`, both reset to 1. All logic uses the second flop (`rx_s`). A third flop `rx_prev` (reset 1) is used for edge detection.
- Tick generator: free-running counter 0..DIVISOR-1, reset 0. `tick` is high for one clk when the count equals DIVISOR-1, then the count wraps to 0. It runs in every state.
- Datapath counters:
  - `s_cnt`, 4 bits: counts ticks within the current bit.
  - `n_cnt`, 3 bits: counts data bits.
  - `shreg`, 8 bits: shift register.
- State machine: IDLE, START, DATA, STOP. Reset state is IDLE.
- IDLE:
  - On a falling edge (`rx_prev`=1 and `rx_s`=0), go to START and clear `s_cnt`.
  - A line that is merely held low never starts a frame.
- START (counts on ticks):
  - When `s_cnt`=7 (mid start bit): if `rx_s`=0, go to DATA and clear `s_cnt` and `n_cnt`.
  - If `rx_s`=1 at that point, the low was a glitch: go to IDLE with no output pulse.
- DATA (counts on ticks):
  - When `s_cnt`=15, shift right: `shreg <= {rx_s, shreg[7:1]}`. Clear `s_cnt`.
  - If `n_cnt`=7, go to STOP; otherwise increment `n_cnt`.
- STOP (counts on ticks):
  - When `s_cnt`=15 and `rx_s`=1: load `o_rx_data <= shreg`, pulse `os_rx_done`, go to IDLE.
  - When `s_cnt`=15 and `rx_s`=0: pulse `os_frame_err`, leave `o_rx_data` unchanged, go to IDLE.
- `o_rx_data` holds its value until the next good frame. Consumers may sample it during or after the pulse.
- The two output pulses are mutually exclusive and never last longer than one clk.
- Bytes 0x01/0x02/0x03 carry no special meaning here; decoding is the consumer's job.

## Timing
- Reset values: `o_rx_data`=0x00, `os_rx_done`=0, `os_frame_err`=0, `o_busy`=0, state IDLE, all counters 0.
- Reset assertion mid-frame takes effect immediately (asynchronous). The partial byte is lost, no pulse is produced, and the next falling edge after release starts a fresh frame.
- Edge detect latency: 3 clk from the `i_rx` fall to START.
- Sample points relative to the detected edge (tick-phase uncertainty of up to DIVISOR-1 clk on each):
  - start bit at tick 8;
  - data bit k at tick 8+16(k+1);
  - stop bit at tick 152.
- `os_rx_done` / `os_frame_err` are registered: asserted the clk after the stop sample tick.
- Falling-edge-to-pulse latency: between 152·DIVISOR+3 and 153·DIVISOR+4 clk.
- Back-to-back frames: the block returns to IDLE mid stop bit, so a start edge arriving ≥ 8 ticks later is caught. Frames with zero idle gap are supported.
- Tolerates ±3% baud mismatch.
- Line held low (break) after a framing error: stays in IDLE, with no further events until a rising edge followed by a new fall.

## Test plan
- Reset: hold `rst`=0 with `i_rx` toggling. All outputs stay at their reset values and `o_busy`=0. Release, keep the line idle 1000 clk: no pulses.
- Single byte, DIVISOR=4 (64 clk/bit): send 0xA5 8N1. Exactly one `os_rx_done` pulse within [611, 616] clk of the fall, with `o_rx_data`=0xA5, `os_frame_err` never high, and `o_busy` low after the pulse.
- Back-to-back commands 0x01, 0x02, 0x03 with no idle gap. Three `os_rx_done` pulses in order with matching data, spaced 640 clk ±4.
- Glitch: drive `i_rx` low for 3·DIVISOR clk then high. No pulse. `o_busy` high then low by tick 8. A following 0x5A frame is received correctly.
- Framing error: first receive 0x11, then send 0x3C with stop bit 0 and hold the line low for 3 frame times. One `os_frame_err` pulse, no `os_rx_done`, and `o_rx_data` stays 0x11. After release high, 0x3C is received correctly.
- Reset mid-frame: assert `rst` during data bit 4 of 0xFF. Outputs clear immediately. After release, a frame of 0x80 yields `o_rx_data`=0x80 with one pulse.
